mips_lsu: RTL

- Load/store unit directly downstream of the core's ALU/address path; sole owner of the data-memory port (mem_addr, mem_data_in, mem_write_en).
- Accepts one byte/half/word load or store per request and drives a req/rdy handshake to data memory.
- Returns extracted, extended load data or store completion, with alignment (AdEL/AdES) and bus-error (DBE) status for the exception unit.
- Stalls the core (PC/regfile enables) while an access is outstanding.

---
 rtl/mips_lsu_if.sv | 38 +++
 rtl/mips_lsu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_lsu_if.sv
// Core-side request/response and data-memory port bundle for the MIPS load/store unit.
interface mips_lsu_if;
  logic        lsu_req;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_stall;
  logic        lsu_adel;
  logic        lsu_ades;
  logic        lsu_dbe;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_write_en;
  logic        mem_rdy;
  logic [31:0] mem_data_out;
  logic        mem_excpt;

  // Core pipeline plus data memory: drives requests and memory responses.
  modport master (
    output lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    output mem_rdy, mem_data_out, mem_excpt,
    input  lsu_rdata, lsu_done, lsu_stall, lsu_adel, lsu_ades, lsu_dbe,
    input  mem_req, mem_addr, mem_data_in, mem_write_en
  );

  // The load/store unit itself.
  modport slave (
    input  lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    input  mem_rdy, mem_data_out, mem_excpt,
    output lsu_rdata, lsu_done, lsu_stall, lsu_adel, lsu_ades, lsu_dbe,
    output mem_req, mem_addr, mem_data_in, mem_write_en
  );
endinterface

// File: rtl/mips_lsu.sv
// MIPS load/store unit: byte/half/word access to data memory with AdEL/AdES/DBE status.
// Define LSU_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES cycles without mem_rdy.
module mips_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_b,
  mips_lsu_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mips_lsu: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        adel_q, adel_d;
  logic        ades_q, ades_d;
  logic        dbe_q, dbe_d;

  logic        fault_c;
  logic [3:0]  st_mask_c;
  logic [31:0] st_data_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_ext_c;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Alignment check and store lane steering from the incoming request.
  always_comb begin
    fault_c   = 1'b0;
    st_mask_c = 4'b0000;
    st_data_c = '0;
    unique case (bus.lsu_size)
      2'b00: begin
        st_mask_c = 4'(4'b0001 << bus.lsu_addr[1:0]);
        st_data_c = {4{bus.lsu_wdata[7:0]}};
      end
      2'b01: begin
        fault_c   = bus.lsu_addr[0];
        st_mask_c = bus.lsu_addr[1] ? 4'b1100 : 4'b0011;
        st_data_c = {2{bus.lsu_wdata[15:0]}};
      end
      2'b10: begin
        fault_c   = (bus.lsu_addr[1:0] != 2'b00);
        st_mask_c = 4'b1111;
        st_data_c = bus.lsu_wdata;
      end
      default: fault_c = 1'b1;
    endcase
  end

  // Load lane selection and extension from the returned memory word.
  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte_c = bus.mem_data_out[7:0];
      2'd1:    ld_byte_c = bus.mem_data_out[15:8];
      2'd2:    ld_byte_c = bus.mem_data_out[23:16];
      default: ld_byte_c = bus.mem_data_out[31:24];
    endcase
    ld_half_c = off_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
    unique case (size_q)
      2'b00:   ld_ext_c = uns_q ? {24'h0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
      2'b01:   ld_ext_c = uns_q ? {16'h0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
      default: ld_ext_c = bus.mem_data_out;
    endcase
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 4'b0000;
    mem_wdata_d = '0;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    adel_d      = 1'b0;
    ades_d      = 1'b0;
    dbe_d       = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.lsu_req) begin
          size_d = bus.lsu_size;
          we_d   = bus.lsu_we;
          uns_d  = bus.lsu_unsigned;
          off_d  = bus.lsu_addr[1:0];
          if (fault_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            adel_d  = ~bus.lsu_we;
            ades_d  = bus.lsu_we;
          end else begin
            state_d    = S_ACCESS;
            mem_req_d  = 1'b1;
            mem_addr_d = bus.lsu_addr[31:2];
            if (bus.lsu_we) begin
              mem_we_d    = st_mask_c;
              mem_wdata_d = st_data_c;
            end
`ifdef LSU_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end

      S_ACCESS: begin
        if (bus.mem_rdy) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          dbe_d   = bus.mem_excpt;
          if (!we_q && !bus.mem_excpt) rdata_d = ld_ext_c;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          dbe_d   = 1'b1;
        end
`endif
        else begin
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      size_q      <= 2'b00;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      dbe_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      adel_q      <= adel_d;
      ades_q      <= ades_d;
      dbe_q       <= dbe_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.lsu_rdata    = rdata_q;
  assign bus.lsu_done     = done_q;
  assign bus.lsu_adel     = adel_q;
  assign bus.lsu_ades     = ades_q;
  assign bus.lsu_dbe      = dbe_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_in  = mem_wdata_q;
  assign bus.mem_write_en = mem_we_q;
  // Core stall follows the live request so it drops in the completion cycle.
  assign bus.lsu_stall    = bus.lsu_req & ~done_q;

endmodule
